// File: rtl/mem_wb_stage.sv
// Memory-access / writeback pipeline stage with an internal word-addressed data memory.
// Each request walks IDLE -> ACCESS -> WB, so one request is serviced every three cycles.
module mem_wb_stage #(
    parameter int N  = 32,
    parameter int AW = 6
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         MemRd,
    input  logic         MemWr,
    input  logic         RegWrIn,
    input  logic [4:0]   RwIn,
    input  logic [N-1:0] AluOut,
    input  logic [N-1:0] StoreData,
    output logic         RegWr,
    output logic [4:0]   Rw,
    output logic [N-1:0] busV,
    output logic         AddrErr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WB     = 2'd2
    } state_t;

    // A memory access is misaligned when its byte address is not word aligned.
    function automatic logic misaligned(input logic rd, input logic wr, input logic [1:0] lsb);
        return (rd || wr) && (lsb != 2'b00);
    endfunction

    state_t         state_r;
    logic           in_ready_r;
    logic           memrd_r;
    logic           memwr_r;
    logic           regwrin_r;
    logic [4:0]     rwin_r;
    logic [N-1:0]   aluout_r;
    logic [N-1:0]   storedata_r;
    logic           regwr_r;
    logic [4:0]     rw_r;
    logic [N-1:0]   busv_r;
    logic           addrerr_r;

    logic [N-1:0]   mem_r [2**AW];

    logic           misalign_s;
    logic [AW-1:0]  word_idx_s;
    logic [N-1:0]   rd_word_s;
    logic [N-1:0]   wb_data_s;
    logic           wb_regwr_s;
    logic           mem_we_s;

    // Decode the captured request into memory control and writeback values
    always_comb begin
        misalign_s = misaligned(memrd_r, memwr_r, aluout_r[1:0]);
        word_idx_s = aluout_r[AW+1:2];
        rd_word_s  = mem_r[word_idx_s];
        wb_regwr_s = regwrin_r && (rwin_r != 5'd0);
        mem_we_s   = (state_r == ACCESS) && memwr_r && !misalign_s;
        // A store (even with MemRd also set) forwards the ALU result, not memory data.
        if (memwr_r) begin
            wb_data_s = aluout_r;
        end else if (memrd_r) begin
            if (misalign_s) begin
                wb_data_s = {N{1'b0}};
            end else begin
                wb_data_s = rd_word_s;
            end
        end else begin
            wb_data_s = aluout_r;
        end
    end

    // Request capture, stage sequencing and registered writeback outputs
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            memrd_r     <= 1'b0;
            memwr_r     <= 1'b0;
            regwrin_r   <= 1'b0;
            rwin_r      <= 5'd0;
            aluout_r    <= {N{1'b0}};
            storedata_r <= {N{1'b0}};
            regwr_r     <= 1'b0;
            rw_r        <= 5'd0;
            busv_r      <= {N{1'b0}};
            addrerr_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        state_r     <= ACCESS;
                        in_ready_r  <= 1'b0;
                        memrd_r     <= MemRd;
                        memwr_r     <= MemWr;
                        regwrin_r   <= RegWrIn;
                        rwin_r      <= RwIn;
                        aluout_r    <= AluOut;
                        storedata_r <= StoreData;
                    end
                end
                ACCESS: begin
                    state_r   <= WB;
                    regwr_r   <= wb_regwr_s;
                    rw_r      <= rwin_r;
                    busv_r    <= wb_data_s;
                    addrerr_r <= misalign_s;
                end
                WB: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b1;
                    regwr_r    <= 1'b0;
                    rw_r       <= 5'd0;
                    busv_r     <= {N{1'b0}};
                    addrerr_r  <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b1;
                    regwr_r    <= 1'b0;
                    rw_r       <= 5'd0;
                    busv_r     <= {N{1'b0}};
                    addrerr_r  <= 1'b0;
                end
            endcase
        end
    end

    // Data memory write; contents deliberately survive reset
    always_ff @(posedge Clock) begin
        if (mem_we_s) begin
            mem_r[word_idx_s] <= storedata_r;
        end
    end

    assign in_ready = in_ready_r;
    assign RegWr    = regwr_r;
    assign Rw       = rw_r;
    assign busV     = busv_r;
    assign AddrErr  = addrerr_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed literal cases plus randomized traffic checked
// every cycle against a timeline/memory-array model of the stage.
module tb_mem_wb_stage;
    localparam int N  = 32;
    localparam int AW = 6;

    logic         Clock;
    logic         Reset_n;
    logic         in_valid;
    logic         in_ready;
    logic         MemRd;
    logic         MemWr;
    logic         RegWrIn;
    logic [4:0]   RwIn;
    logic [N-1:0] AluOut;
    logic [N-1:0] StoreData;
    logic         RegWr;
    logic [4:0]   Rw;
    logic [N-1:0] busV;
    logic         AddrErr;

    int total = 0;
    int bad   = 0;

    mem_wb_stage #(.N(N), .AW(AW)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .MemRd(MemRd), .MemWr(MemWr), .RegWrIn(RegWrIn), .RwIn(RwIn),
        .AluOut(AluOut), .StoreData(StoreData), .RegWr(RegWr), .Rw(Rw),
        .busV(busV), .AddrErr(AddrErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request accepted at edge a produces its results after edge a+1
    // and the stage is free again after edge a+2.
    bit           pend = 1'b0;
    int           cyc = 0;
    int           acc_cyc = 0;
    logic         q_rd, q_wr, q_rwe;
    logic [4:0]   q_rw;
    logic [N-1:0] q_alu, q_sd;
    logic [N-1:0] mm [2**AW];
    bit           known [2**AW];
    logic         e_ready = 1'b1;
    logic         e_regwr = 1'b0;
    logic [4:0]   e_rw = 5'd0;
    logic [N-1:0] e_busv = '0;
    logic         e_err = 1'b0;
    bit           e_bk = 1'b1;
    int           w;
    bit           mis;

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pend = 1'b0; e_ready = 1'b1; e_regwr = 1'b0; e_rw = 5'd0;
            e_busv = '0; e_err = 1'b0; e_bk = 1'b1;
        end else begin
            cyc++;
            if (pend && cyc == acc_cyc + 2) begin
                pend = 1'b0; e_ready = 1'b1; e_regwr = 1'b0; e_rw = 5'd0;
                e_busv = '0; e_err = 1'b0; e_bk = 1'b1;
            end else if (pend && cyc == acc_cyc + 1) begin
                mis = (q_rd || q_wr) && (q_alu % 4 != 0);
                w   = int'(q_alu / 4) % (2**AW);
                e_bk = 1'b1;
                if (q_wr) begin
                    if (!mis) begin
                        mm[w] = q_sd;
                        known[w] = 1'b1;
                    end
                    e_busv = q_alu;
                end else if (q_rd) begin
                    e_busv = mis ? '0 : mm[w];
                    e_bk   = mis || known[w];
                end else begin
                    e_busv = q_alu;
                end
                e_rw    = q_rw;
                e_regwr = q_rwe && (q_rw != 5'd0);
                e_err   = mis;
            end else if (!pend && in_valid) begin
                q_rd = MemRd; q_wr = MemWr; q_rwe = RegWrIn; q_rw = RwIn;
                q_alu = AluOut; q_sd = StoreData;
                acc_cyc = cyc; pend = 1'b1; e_ready = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge Clock) begin
        chk("in_ready", 32'(in_ready), 32'(e_ready));
        chk("RegWr", 32'(RegWr), 32'(e_regwr));
        chk("Rw", 32'(Rw), 32'(e_rw));
        chk("AddrErr", 32'(AddrErr), 32'(e_err));
        if (e_bk) chk("busV", busV, e_busv);
    end

    task automatic do_req(input logic rd, input logic wr, input logic rwe, input logic [4:0] rw,
                          input logic [N-1:0] alu, input logic [N-1:0] sd, input bit hold);
        int tries;
        tries = 0;
        @(negedge Clock);
        in_valid = 1'b1; MemRd = rd; MemWr = wr; RegWrIn = rwe; RwIn = rw;
        AluOut = alu; StoreData = sd;
        while (in_ready !== 1'b1 && tries < 8) begin
            @(negedge Clock);
            tries++;
        end
        if (tries >= 8) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready got %b want 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge Clock);
            #1;
            if (!hold) in_valid = 1'b0;
        end
    endtask

    task automatic wb_check(input string name, input logic [4:0] rw, input logic [N-1:0] bv,
                            input logic rwe, input logic err);
        @(negedge Clock);
        @(negedge Clock);
        chk({name, "_Rw"}, 32'(Rw), 32'(rw));
        chk({name, "_busV"}, busV, bv);
        chk({name, "_RegWr"}, 32'(RegWr), 32'(rwe));
        chk({name, "_AddrErr"}, 32'(AddrErr), 32'(err));
    endtask

    int pulses;

    initial begin
        Reset_n = 1'b0; in_valid = 1'b0; MemRd = 1'b0; MemWr = 1'b0; RegWrIn = 1'b0;
        RwIn = 5'd0; AluOut = '0; StoreData = '0;
        for (int i = 0; i < 2**AW; i++) known[i] = 1'b0;
        @(negedge Clock);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_RegWr", 32'(RegWr), 32'd0);
        chk("rst_busV", busV, 32'd0);
        #2 Reset_n = 1'b1;

        do_req(1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h0, 1'b0);
        wb_check("alu", 5'd5, 32'h1234, 1'b1, 1'b0);
        do_req(1'b0, 1'b1, 1'b0, 5'd0, 32'h10, 32'hDEADBEEF, 1'b0);
        wb_check("store10", 5'd0, 32'h10, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 1'b1, 5'd3, 32'h10, 32'h0, 1'b0);
        wb_check("load10", 5'd3, 32'hDEADBEEF, 1'b1, 1'b0);
        do_req(1'b0, 1'b1, 1'b0, 5'd0, 32'h100, 32'hA5A5A5A5, 1'b0);
        wb_check("store100", 5'd0, 32'h100, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 1'b1, 5'd6, 32'h0, 32'h0, 1'b0);
        wb_check("wrap_load0", 5'd6, 32'hA5A5A5A5, 1'b1, 1'b0);
        do_req(1'b1, 1'b0, 1'b1, 5'd4, 32'h13, 32'h0, 1'b0);
        wb_check("misld13", 5'd4, 32'h0, 1'b1, 1'b1);
        do_req(1'b0, 1'b1, 1'b0, 5'd0, 32'h12, 32'h0BADF00D, 1'b0);
        wb_check("misst12", 5'd0, 32'h12, 1'b0, 1'b1);
        do_req(1'b1, 1'b0, 1'b1, 5'd8, 32'h10, 32'h0, 1'b0);
        wb_check("reload10", 5'd8, 32'hDEADBEEF, 1'b1, 1'b0);
        do_req(1'b0, 1'b0, 1'b1, 5'd0, 32'h77, 32'h0, 1'b0);
        wb_check("rw0", 5'd0, 32'h77, 1'b0, 1'b0);
        do_req(1'b1, 1'b1, 1'b1, 5'd2, 32'h24, 32'h00000077, 1'b0);
        wb_check("rdwr24", 5'd2, 32'h24, 1'b1, 1'b0);
        do_req(1'b1, 1'b0, 1'b1, 5'd2, 32'h24, 32'h0, 1'b0);
        wb_check("load24", 5'd2, 32'h77, 1'b1, 1'b0);

        // in_valid held high: only one accept per pass through IDLE
        @(negedge Clock);
        in_valid = 1'b1; MemRd = 1'b0; MemWr = 1'b0; RegWrIn = 1'b1; RwIn = 5'd7; AluOut = 32'h55;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            if (RegWr) pulses++;
        end
        in_valid = 1'b0;
        chk("held_valid_pulses", 32'(pulses), 32'd2);

        // Reset during ACCESS of a store aborts it
        do_req(1'b0, 1'b1, 1'b0, 5'd0, 32'h20, 32'h11111111, 1'b0);
        wb_check("store20", 5'd0, 32'h20, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 1'b1, 5'd9, 32'h20, 32'h22222222, 1'b0);
        @(negedge Clock);
        #2 Reset_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_RegWr", 32'(RegWr), 32'd0);
        chk("abort_Rw", 32'(Rw), 32'd0);
        chk("abort_busV", busV, 32'd0);
        @(negedge Clock);
        #2 Reset_n = 1'b1;
        do_req(1'b1, 1'b0, 1'b1, 5'd3, 32'h20, 32'h0, 1'b0);
        wb_check("after_abort20", 5'd3, 32'h11111111, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [N-1:0] a;
            logic [1:0]   op;
            bit           hold;
            a = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 3) == 0) a[31:8] = 24'($urandom);
            if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
            op   = 2'($urandom_range(0, 3));
            hold = ($urandom_range(0, 3) == 0);
            do_req(op[0], op[1], 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                   a, 32'($urandom), hold);
            if (!hold && $urandom_range(0, 4) == 0) repeat (2) @(negedge Clock);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter N, default 32: data width of AluOut, StoreData, busV.
REQ-002 Parameter AW, default 6: data-memory word-address width (2^AW words).
REQ-003 The block SHALL have one clock, Clock, and one reset, Reset_n; reset is asynchronous and active-low.
REQ-004 Clock  in  1  rising-edge clock for all state.
REQ-005 Reset_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  upstream request valid.
REQ-007 in_ready  out  1  block can accept a request.
REQ-008 MemRd  in  1  request is a load.
REQ-009 MemWr  in  1  request is a store.
REQ-010 RegWrIn  in  1  request writes a register.
REQ-011 RwIn  in  5  destination register number.
REQ-012 AluOut  in  N  ALU result and byte address.
REQ-013 StoreData  in  N  store data.
REQ-014 RegWr  out  1  register-file write enable, one-cycle pulse.
REQ-015 Rw  out  5  register-file write address.
REQ-016 busV  out  N  register-file write data.
REQ-017 AddrErr  out  1  misaligned-access flag, one-cycle pulse.

Function
REQ-018 The block SHALL contain a 2^AW x N data memory; word index = AluOut[AW+1:2]; higher address bits ignored, so addresses wrap modulo 2^AW words.
REQ-019 FSM states: IDLE, ACCESS, WB; IDLE->ACCESS on in_valid&&in_ready, ACCESS->WB always, WB->IDLE always.
REQ-020 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE is ignored and upstream holds the request.
REQ-021 On accept, all request inputs are captured; inputs are don't-care afterwards.
REQ-022 On the ACCESS->WB edge: a store writes StoreData to memory; a load captures the addressed word.
REQ-023 MemRd&&MemWr together: treated as store only; busV = AluOut.
REQ-024 Misaligned access (MemRd or MemWr, AluOut[1:0]!=0): store suppressed, load data = 0, AddrErr=1 during WB.
REQ-025 In WB: Rw = captured RwIn; busV = load data if load, else captured AluOut; RegWr = RegWrIn && RwIn!=0.
REQ-026 Rw=0 requests SHALL never assert RegWr.
REQ-027 Outside WB: RegWr=0, AddrErr=0, Rw=0, busV=0; all outputs registered.
REQ-028 Latency: accept on edge k, outputs valid throughout cycle k+2 (so a negedge-writing register file writes mid-cycle k+2); throughput one request per 3 cycles.
REQ-029 A load following a store to the same word SHALL return the stored data.

Reset
REQ-030 Reset_n=0 SHALL immediately force state IDLE, in_ready=1, RegWr=0, AddrErr=0, Rw=0, busV=0.
REQ-031 Reset asserted before the ACCESS->WB edge aborts the request: no memory write, no RegWr pulse.
REQ-032 Memory contents are not cleared by reset and are undefined at power-up.

Verification
REQ-033 ALU op: RegWrIn=1, RwIn=5, AluOut=0x1234 -> two cycles later RegWr=1 for one cycle, Rw=5, busV=0x1234.
REQ-034 Store then load: store StoreData=0xDEADBEEF at AluOut=0x10, then load RwIn=3 from 0x10 -> busV=0xDEADBEEF, Rw=3, RegWr=1.
REQ-035 Wrap: store 0xA5A5A5A5 at AluOut=0x100 (AW=6), load from 0x0 -> busV=0xA5A5A5A5.
REQ-036 Misaligned load AluOut=0x13, RwIn=4 -> AddrErr=1, busV=0, RegWr=1; misaligned store leaves word 0x10 unchanged.
REQ-037 RwIn=0, RegWrIn=1 -> RegWr stays 0; in_valid held high during ACCESS/WB -> second request accepted only after return to IDLE.
REQ-038 Reset_n low during ACCESS of a store to 0x20 -> outputs zero immediately, no RegWr, later load of 0x20 returns prior contents.
